// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump/load controller.
package reg_dump_pkg;

   localparam int   REG_ADDR_W = 5;
   localparam int   DATA_W     = 32;
   localparam logic MODE_DUMP  = 1'b0;
   localparam logic MODE_LOAD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_CAP,
      RD_OUT,
      LD_ACC,
      LD_WR,
      DONE
   } state_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Control, register-file and stream signals of reg_dump_ctrl.
interface reg_dump_ctrl_if;
   import reg_dump_pkg::*;

   logic                  start;
   logic                  mode;
   logic                  busy;
   logic                  done;
   logic [REG_ADDR_W-1:0] ReadAddr;
   logic [DATA_W-1:0]     ReadData;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] WriteAddr;
   logic [DATA_W-1:0]     WriteData;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [REG_ADDR_W-1:0] dout_addr;
   logic [DATA_W-1:0]     dout_data;
   logic                  din_valid;
   logic                  din_ready;
   logic [DATA_W-1:0]     din_data;

   modport slave (
      input  start, mode, ReadData,
      input  dout_ready, din_valid, din_data,
      output busy, done, ReadAddr,
      output RegWrite, WriteAddr, WriteData,
      output dout_valid, dout_addr, dout_data,
      output din_ready
   );

   modport master (
      output start, mode, ReadData,
      output dout_ready, din_valid, din_data,
      input  busy, done, ReadAddr,
      input  RegWrite, WriteAddr, WriteData,
      input  dout_valid, dout_addr, dout_data,
      input  din_ready
   );

endinterface

// File: rtl/reg_dump_ctrl.sv
// Streams registers FIRST_REG..LAST_REG out of (dump) or into (load)
// an external register file; every output is a flop.
module reg_dump_ctrl
   import reg_dump_pkg::*;
#(
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 31
) (
   input logic           clk,
   input logic           rst,
   reg_dump_ctrl_if.slave bus
);

   localparam logic [REG_ADDR_W-1:0] IDX_FIRST = REG_ADDR_W'(FIRST_REG);
   localparam logic [REG_ADDR_W-1:0] IDX_LAST  = REG_ADDR_W'(LAST_REG);

   state_t                r_state, w_state_nxt;
   logic [REG_ADDR_W-1:0] r_idx, w_idx_nxt;
   logic                  w_last;
   logic                  w_ld_acc;

   logic                  r_busy, w_busy;
   logic                  r_done, w_done;
   logic                  r_reg_write, w_reg_write;
   logic                  r_dout_valid, w_dout_valid;
   logic                  r_din_ready, w_din_ready;
   logic [REG_ADDR_W-1:0] r_read_addr, w_read_addr;
   logic [REG_ADDR_W-1:0] r_write_addr, w_write_addr;
   logic [REG_ADDR_W-1:0] r_dout_addr, w_dout_addr;
   logic [DATA_W-1:0]     r_write_data, w_write_data;
   logic [DATA_W-1:0]     r_dout_data, w_dout_data;

   assign w_last   = (r_idx == IDX_LAST);
   assign w_ld_acc = (r_state == LD_ACC) && bus.din_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_idx_nxt = IDX_FIRST;
               unique case (bus.mode)
                  MODE_DUMP: w_state_nxt = RD_ISSUE;
                  MODE_LOAD: w_state_nxt = LD_ACC;
                  default:   w_state_nxt = IDLE;
               endcase
            end
         end
         RD_ISSUE: w_state_nxt = RD_CAP;
         RD_CAP:   w_state_nxt = RD_OUT;
         RD_OUT: begin
            if (bus.dout_ready) begin
               if (w_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = RD_ISSUE;
               end
            end
         end
         LD_ACC: begin
            if (bus.din_valid) w_state_nxt = LD_WR;
         end
         LD_WR: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = LD_ACC;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered,
   // so each one is valid for exactly the cycles of its state.
   always_comb begin
      w_busy       = (w_state_nxt != IDLE);
      w_done       = (w_state_nxt == DONE);
      w_reg_write  = (w_state_nxt == LD_WR);
      w_din_ready  = (w_state_nxt == LD_ACC);
      w_dout_valid = (w_state_nxt == RD_OUT);
      w_read_addr  = '0;
      if (w_state_nxt inside {RD_ISSUE, RD_CAP, RD_OUT})
         w_read_addr = w_idx_nxt;
      w_write_addr = r_write_addr;
      w_write_data = r_write_data;
      if (w_ld_acc) begin
         w_write_addr = r_idx;
         w_write_data = bus.din_data;
      end
      w_dout_addr = r_dout_addr;
      w_dout_data = r_dout_data;
      if (r_state == RD_CAP) begin
         w_dout_addr = r_idx;
         w_dout_data = bus.ReadData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_reg_write  <= 1'b0;
         r_din_ready  <= 1'b0;
         r_dout_valid <= 1'b0;
         r_read_addr  <= '0;
         r_write_addr <= '0;
         r_write_data <= '0;
         r_dout_addr  <= '0;
         r_dout_data  <= '0;
      end else begin
         r_busy       <= w_busy;
         r_done       <= w_done;
         r_reg_write  <= w_reg_write;
         r_din_ready  <= w_din_ready;
         r_dout_valid <= w_dout_valid;
         r_read_addr  <= w_read_addr;
         r_write_addr <= w_write_addr;
         r_write_data <= w_write_data;
         r_dout_addr  <= w_dout_addr;
         r_dout_data  <= w_dout_data;
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.RegWrite   = r_reg_write;
   assign bus.din_ready  = r_din_ready;
   assign bus.dout_valid = r_dout_valid;
   assign bus.ReadAddr   = r_read_addr;
   assign bus.WriteAddr  = r_write_addr;
   assign bus.WriteData  = r_write_data;
   assign bus.dout_addr  = r_dout_addr;
   assign bus.dout_data  = r_dout_data;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Scoreboard bench for reg_dump_ctrl: random dump/load traffic against
// a register-file model, with a second instance for a narrow load range.
module tb_reg_dump_ctrl;
   import reg_dump_pkg::*;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   reg_dump_ctrl_if bus ();
   reg_dump_ctrl_if bus_b ();

   reg_dump_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   reg_dump_ctrl #(
      .FIRST_REG (5),
      .LAST_REG  (7)
   ) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   logic [31:0] mem   [32];
   logic [31:0] mem_b [32];
   logic [31:0] ref_mem [32];

   word_t exp_dump[$];
   word_t exp_wr[$];
   word_t exp_wr_b[$];
   int    exp_done[$];
   int    done_b_cnt = 0;
   int    rdy_mode = 0;
   int    stall_cnt = 0;

   // register files: synchronous read, synchronous write
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc == 0) begin
         for (int i = 0; i < 32; i++) begin
            mem[i]   <= 32'h100 + 32'(i);
            mem_b[i] <= 32'h100 + 32'(i);
         end
      end else begin
         if (bus.RegWrite) mem[bus.WriteAddr] <= bus.WriteData;
         if (bus_b.RegWrite) mem_b[bus_b.WriteAddr] <= bus_b.WriteData;
      end
      bus.ReadData   <= mem[bus.ReadAddr];
      bus_b.ReadData <= mem_b[bus_b.ReadAddr];
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic fail(string nm);
      checks++;
      errors++;
      $display("FAIL %s: got event want none", nm);
   endtask

   // consumer ready pattern, updated just after each rising edge
   initial forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) begin
         bus.dout_ready = 1'b1;
      end else if (bus.dout_valid && bus.dout_addr == 5'd3
                   && stall_cnt < 10) begin
         bus.dout_ready = 1'b0;
         stall_cnt++;
      end else begin
         bus.dout_ready = 1'($urandom_range(0, 1));
      end
   end

   // monitor for the default-range instance
   initial begin
      logic        pv_hold;
      logic [4:0]  pv_addr;
      logic [31:0] pv_data;
      word_t       w;
      int          e;
      pv_hold = 1'b0;
      pv_addr = '0;
      pv_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv_hold = 1'b0;
         end else begin
            if (bus.dout_valid) begin
               chk("rdaddr_out", 64'(bus.ReadAddr), 64'(bus.dout_addr));
               if (pv_hold) begin
                  chk("stall_addr", 64'(bus.dout_addr), 64'(pv_addr));
                  chk("stall_data", 64'(bus.dout_data), 64'(pv_data));
               end
               if (bus.dout_ready) begin
                  if (exp_dump.size() == 0) begin
                     fail("dump_extra");
                  end else begin
                     w = exp_dump.pop_front();
                     chk("dump_addr", 64'(bus.dout_addr), 64'(w.a));
                     chk("dump_data", 64'(bus.dout_data), 64'(w.d));
                  end
               end
               pv_hold = !bus.dout_ready;
               pv_addr = bus.dout_addr;
               pv_data = bus.dout_data;
            end else begin
               pv_hold = 1'b0;
            end
            if (bus.RegWrite) begin
               chk("wr_addr_nz", 64'(bus.WriteAddr != 5'd0), 64'd1);
               chk("wr_din_rdy", 64'(bus.din_ready), 64'd0);
               chk("wr_busy", 64'(bus.busy), 64'd1);
               if (exp_wr.size() == 0) begin
                  fail("wr_extra");
               end else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", 64'(bus.WriteAddr), 64'(w.a));
                  chk("wr_data", 64'(bus.WriteData), 64'(w.d));
               end
            end
            if (bus.done) begin
               chk("done_busy", 64'(bus.busy), 64'd1);
               if (exp_done.size() == 0) begin
                  fail("done_extra");
               end else begin
                  e = exp_done.pop_front();
                  if (e >= 0) chk("done_cycle", 64'(cyc), 64'(e));
               end
            end
         end
      end
   end

   // monitor for the narrow-range instance
   initial begin
      word_t w;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus_b.RegWrite) begin
               chk("b_wr_nz", 64'(bus_b.WriteAddr != 5'd0), 64'd1);
               if (exp_wr_b.size() == 0) begin
                  fail("b_wr_extra");
               end else begin
                  w = exp_wr_b.pop_front();
                  chk("b_wr_addr", 64'(bus_b.WriteAddr), 64'(w.a));
                  chk("b_wr_data", 64'(bus_b.WriteData), 64'(w.d));
               end
            end
            if (bus_b.done) done_b_cnt++;
         end
      end
   end

   task automatic wait_done(string nm);
      int t;
      t = 0;
      while (exp_done.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (exp_done.size() != 0) begin
         fail(nm);
         exp_done.delete();
      end
   endtask

   task automatic do_dump(bit noise, bit timed);
      int s;
      int t;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = MODE_DUMP;
      s = cyc + 1;
      for (int i = 1; i <= 31; i++)
         exp_dump.push_back('{5'(i), ref_mem[i]});
      exp_done.push_back(timed ? s + 93 : -1);
      @(negedge clk);
      bus.start = 1'b0;
      t = 0;
      while (exp_done.size() != 0 && t < 3000) begin
         if (noise && exp_dump.size() > 2) begin
            bus.start     = 1'($urandom);
            bus.mode      = 1'($urandom);
            bus.din_valid = 1'($urandom);
            bus.din_data  = $urandom;
         end else begin
            bus.start     = 1'b0;
            bus.din_valid = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      bus.start     = 1'b0;
      bus.din_valid = 1'b0;
      if (exp_done.size() != 0) begin
         fail("dump_timeout");
         exp_done.delete();
      end
      chk("dump_left", 64'(exp_dump.size()), 64'd0);
      exp_dump.delete();
   endtask

   task automatic do_load(int n, bit abort);
      int t;
      int gap;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = MODE_LOAD;
      if (!abort) exp_done.push_back(-1);
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, 4);
         repeat (gap) begin
            bus.start = 1'($urandom);
            bus.mode  = 1'($urandom);
            @(negedge clk);
         end
         bus.start     = 1'b0;
         bus.din_valid = 1'b1;
         bus.din_data  = $urandom;
         t = 0;
         while (!bus.din_ready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) begin
            fail("din_timeout");
            bus.din_valid = 1'b0;
            return;
         end
         exp_wr.push_back('{5'(1 + k), bus.din_data});
         if (!(abort && k == 3)) ref_mem[1 + k] = bus.din_data;
         @(negedge clk);
         bus.din_valid = 1'b0;
         if (abort && k == 3) begin
            #1 rst = 1'b1;
            #1;
            chk("abort_regwrite", 64'(bus.RegWrite), 64'd0);
            chk("abort_busy", 64'(bus.busy), 64'd0);
            chk("abort_din_rdy", 64'(bus.din_ready), 64'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (6) @(negedge clk);
            chk("abort_wr_left", 64'(exp_wr.size()), 64'd0);
            return;
         end
      end
      wait_done("load_timeout");
      chk("load_wr_left", 64'(exp_wr.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] vals[3];
      int t;
      vals = '{32'hA, 32'hB, 32'hC};
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h100 + 32'(i);
      bus.start = 1'b0;
      bus.mode = 1'b0;
      bus.din_valid = 1'b0;
      bus.din_data = '0;
      bus_b.start = 1'b0;
      bus_b.mode = 1'b0;
      bus_b.din_valid = 1'b0;
      bus_b.din_data = '0;
      bus_b.dout_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_ctl", 64'({bus.busy, bus.done, bus.RegWrite,
                          bus.dout_valid, bus.din_ready}), 64'd0);
      chk("rst_addr", 64'({bus.ReadAddr, bus.WriteAddr,
                           bus.dout_addr}), 64'd0);
      chk("rst_wdata", 64'(bus.WriteData), 64'd0);
      chk("rst_ddata", 64'(bus.dout_data), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      rdy_mode = 0;
      do_dump(1'b0, 1'b1);

      @(negedge clk);
      bus_b.start = 1'b1;
      bus_b.mode  = MODE_LOAD;
      @(negedge clk);
      bus_b.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus_b.din_valid = 1'b1;
         bus_b.din_data  = vals[k];
         t = 0;
         while (!bus_b.din_ready && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) fail("b_din_timeout");
         exp_wr_b.push_back('{5'(5 + k), vals[k]});
         @(negedge clk);
         bus_b.din_valid = 1'b0;
      end
      t = 0;
      while (done_b_cnt == 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("b_done_cnt", 64'(done_b_cnt), 64'd1);
      chk("b_wr_left", 64'(exp_wr_b.size()), 64'd0);
      chk("b_r5", 64'(mem_b[5]), 64'hA);
      chk("b_r6", 64'(mem_b[6]), 64'hB);
      chk("b_r7", 64'(mem_b[7]), 64'hC);
      chk("b_r0", 64'(mem_b[0]), 64'h100);
      chk("b_r8", 64'(mem_b[8]), 64'h108);

      do_load(31, 1'b0);

      rdy_mode = 1;
      stall_cnt = 0;
      do_dump(1'b1, 1'b0);
      chk("stall_len", 64'(stall_cnt), 64'd10);

      rdy_mode = 0;
      do_load(31, 1'b1);
      do_dump(1'b0, 1'b1);

      chk("r0_intact", 64'(mem[0]), 64'h100);
      chk("final_wr_left", 64'(exp_wr.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
